// File: rtl/ascii_dec_parser.sv
// ASCII decimal line parser: buffers up to MAX_DIGITS BCD digits and converts them
// MSB-first into a binary value on a line terminator. Define BACKSPACE_EN to enable 0x08 editing.
module ascii_dec_parser #(
    parameter int MAX_DIGITS = 5,
    parameter int OUT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             busy,
    output logic [OUT_W-1:0] value,
    output logic             value_valid,
    output logic             err_char,
    output logic             err_ovf,
    output logic [2:0]       digit_cnt
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    state_e           r_state;
    logic [3:0]       r_buf [MAX_DIGITS];
    logic [2:0]       r_digit_cnt;
    logic [2:0]       r_conv_idx;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] r_value;
    logic             r_busy;
    logic             r_value_valid;
    logic             r_err_char;
    logic             r_err_ovf;

    logic             w_is_digit;
    logic             w_is_term;
    logic             w_is_space;
    logic             w_is_bs;
    logic [3:0]       w_digit;
    logic [OUT_W-1:0] w_acc_next;
    logic             w_last;

    assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign w_is_space = (rx_data == 8'h20);
    assign w_is_bs    = (rx_data == 8'h08);

    // acc*10 as two shifts and an add; result wraps at OUT_W bits.
    assign w_digit    = r_buf[r_conv_idx];
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {{(OUT_W-4){1'b0}}, w_digit};
    assign w_last     = ((r_conv_idx + 3'd1) == r_digit_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_COLLECT;
            r_digit_cnt   <= '0;
            r_conv_idx    <= '0;
            r_acc         <= '0;
            r_value       <= '0;
            r_busy        <= 1'b0;
            r_value_valid <= 1'b0;
            r_err_char    <= 1'b0;
            r_err_ovf     <= 1'b0;
            // NOTE: the digit buffer is only a few flops, so it is reset with everything else
            // rather than left undefined like a RAM would be.
            for (int i = 0; i < MAX_DIGITS; i++) r_buf[i] <= '0;
        end else begin
            r_value_valid <= 1'b0;
            r_err_char    <= 1'b0;
            r_err_ovf     <= 1'b0;

            case (r_state)
                ST_COLLECT: begin
                    if (rx_valid) begin
                        if (w_is_digit) begin
                            if (r_digit_cnt < MAX_CNT) begin
                                r_buf[r_digit_cnt] <= rx_data[3:0];
                                r_digit_cnt        <= r_digit_cnt + 3'd1;
                            end else begin
                                r_err_ovf   <= 1'b1;
                                r_digit_cnt <= '0;
                                for (int i = 0; i < MAX_DIGITS; i++) r_buf[i] <= '0;
                                r_state     <= ST_DISCARD;
                            end
                        end else if (w_is_term) begin
                            // An empty line (e.g. the LF of CR+LF) is silently ignored.
                            if (r_digit_cnt != 3'd0) begin
                                r_state    <= ST_CONVERT;
                                r_busy     <= 1'b1;
                                r_acc      <= '0;
                                r_conv_idx <= '0;
                            end
                        end else if (w_is_space) begin
                            r_digit_cnt <= r_digit_cnt;
`ifdef BACKSPACE_EN
                        end else if (w_is_bs) begin
                            if (r_digit_cnt != 3'd0) begin
                                r_digit_cnt <= r_digit_cnt - 3'd1;
                            end
`endif
                        end else begin
                            r_err_char  <= 1'b1;
                            r_digit_cnt <= '0;
                            for (int i = 0; i < MAX_DIGITS; i++) r_buf[i] <= '0;
                        end
                    end
                end

                ST_CONVERT: begin
                    r_acc      <= w_acc_next;
                    r_conv_idx <= r_conv_idx + 3'd1;
                    if (w_last) begin
                        r_value       <= w_acc_next;
                        r_value_valid <= 1'b1;
                        r_busy        <= 1'b0;
                        r_digit_cnt   <= '0;
                        for (int i = 0; i < MAX_DIGITS; i++) r_buf[i] <= '0;
                        r_state       <= ST_COLLECT;
                    end
                end

                ST_DISCARD: begin
                    if (rx_valid && w_is_term) begin
                        r_state <= ST_COLLECT;
                    end
                end

                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign value       = r_value;
    assign value_valid = r_value_valid;
    assign err_char    = r_err_char;
    assign err_ovf     = r_err_ovf;
    assign digit_cnt   = r_digit_cnt;

endmodule
